// File: rtl/rr_reg_arbiter_pkg.sv
// Shared types and width helpers for the round-robin register-write arbiter.
package rr_reg_arbiter_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned HOLD_DEF = 2;

  // Pointer indexes a requester; counter must reach HOLD-1 with headroom.
  function automatic int unsigned ptrWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cntWidth(input int unsigned h);
    return $clog2(h) + 1;
  endfunction

  localparam int unsigned PTR_W = ptrWidth(NREQ_DEF);
  localparam int unsigned CNT_W = cntWidth(HOLD_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } arbState_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: rotate requests so ptr lands at bit 0, take the lowest
// set bit, rotate the one-hot result back into requester order.
module rr_pick
  import rr_reg_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned PtrW = PTR_W
) (
  input  logic [NREQ-1:0] req,
  input  logic [PtrW-1:0] ptr,
  output logic [NREQ-1:0] pick,
  output logic            valid
);

  logic [NREQ-1:0] reqRot;
  logic [NREQ-1:0] selRot;
  logic            found;

  always_comb begin
    reqRot = '0;
    selRot = '0;
    pick   = '0;
    found  = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      reqRot[i] = req[PtrW'((i + int'(ptr)) % int'(NREQ))];
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (reqRot[i] && !found) begin
        selRot[i] = 1'b1;
        found     = 1'b1;
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      pick[PtrW'((i + int'(ptr)) % int'(NREQ))] = selRot[i];
    end
  end

  assign valid = |req;

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter guarding the write port of one shared DW-bit register:
// grant, hold for HOLD cycles, load the winner's data, ack, rotate priority.
module rr_reg_arbiter
  import rr_reg_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned DW   = 4,
  parameter int unsigned HOLD = HOLD_DEF
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ*DW-1:0] WDATA,
  output logic [NREQ-1:0]    GNT,
  output logic               ACK,
  output logic [DW-1:0]      Q,
  output logic               BUSY
);

  // Package widths cover the default build; other sizes derive their own.
  localparam int unsigned PtrW = (NREQ == NREQ_DEF) ? PTR_W : ptrWidth(NREQ);
  localparam int unsigned CntW = (HOLD == HOLD_DEF) ? CNT_W : cntWidth(HOLD);

  arbState_e       state,   stateNxt;
  logic [PtrW-1:0] ptr,     ptrNxt;
  logic [CntW-1:0] cnt,     cntNxt;
  logic [PtrW-1:0] gIdx,    gIdxNxt;
  logic [NREQ-1:0] gntReg,  gntNxt;
  logic            ackReg,  ackNxt;
  logic [DW-1:0]   qReg,    qNxt;
  logic            busyReg, busyNxt;

  logic [NREQ-1:0] pick;
  logic            pickValid;
  logic [PtrW-1:0] pickIdx;
  logic            reqG;
  logic [DW-1:0]   wSel;

  rr_pick #(
    .NREQ (NREQ),
    .PtrW (PtrW)
  ) uPick (
    .req   (REQ),
    .ptr   (ptr),
    .pick  (pick),
    .valid (pickValid)
  );

  // Encode the one-hot pick into the index remembered for the transaction.
  always_comb begin
    pickIdx = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick[i]) pickIdx = PtrW'(i);
    end
  end

  // Request level and write data of the current grant holder.
  always_comb begin
    reqG = 1'b0;
    wSel = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gIdx == PtrW'(i)) begin
        reqG = REQ[i];
        wSel = WDATA[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      gIdx    <= '0;
      gntReg  <= '0;
      ackReg  <= 1'b0;
      qReg    <= '0;
      busyReg <= 1'b0;
    end else begin
      state   <= stateNxt;
      ptr     <= ptrNxt;
      cnt     <= cntNxt;
      gIdx    <= gIdxNxt;
      gntReg  <= gntNxt;
      ackReg  <= ackNxt;
      qReg    <= qNxt;
      busyReg <= busyNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    ptrNxt   = ptr;
    cntNxt   = cnt;
    gIdxNxt  = gIdx;
    gntNxt   = gntReg;
    ackNxt   = 1'b0;
    qNxt     = qReg;

    unique case (state)
      IDLE: begin
        gntNxt = '0;
        if (pickValid) begin
          gntNxt   = pick;
          gIdxNxt  = pickIdx;
          cntNxt   = '0;
          stateNxt = GRANT;
        end
      end
      GRANT: begin
        // Dropping the request abandons the write without touching PTR or Q.
        if (!reqG) begin
          gntNxt   = '0;
          stateNxt = IDLE;
        end else if (cnt == CntW'(HOLD - 1)) begin
          qNxt     = wSel;
          ackNxt   = 1'b1;
          stateNxt = DONE;
        end else begin
          cntNxt = cnt + CntW'(1);
        end
      end
      DONE: begin
        gntNxt   = '0;
        stateNxt = IDLE;
        ptrNxt   = (gIdx == PtrW'(NREQ - 1)) ? '0 : gIdx + PtrW'(1);
      end
      default: begin
        gntNxt   = '0;
        stateNxt = IDLE;
      end
    endcase

    busyNxt = (stateNxt != IDLE);
  end

  assign GNT  = gntReg;
  assign ACK  = ackReg;
  assign Q    = qReg;
  assign BUSY = busyReg;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: directed scenarios plus random traffic, all
// outputs compared every cycle against a transaction-level reference model.
module tb_rr_reg_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 4;
  localparam int unsigned HOLD = 2;

  logic               CLK;
  logic               RST_N;
  logic [NREQ-1:0]    REQ;
  logic [NREQ*DW-1:0] WDATA;
  logic [NREQ-1:0]    GNT;
  logic               ACK;
  logic [DW-1:0]      Q;
  logic               BUSY;

  int assertCnt;
  int failCnt;

  // Reference model: owner index (-1 = free), cycles spent granted, priority.
  int              mOwner;
  int              mElapsed;
  int              mPtr;
  bit              mDone;
  logic [NREQ-1:0] mGnt;
  logic            mAck;
  logic [DW-1:0]   mQ;
  logic            mBusy;

  rr_reg_arbiter #(
    .NREQ (NREQ),
    .DW   (DW),
    .HOLD (HOLD)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .REQ   (REQ),
    .WDATA (WDATA),
    .GNT   (GNT),
    .ACK   (ACK),
    .Q     (Q),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit reqBit(input logic [NREQ-1:0] req, input int idx);
    return ((req >> idx) & NREQ'(1)) != '0;
  endfunction

  task automatic modelEdge(input logic rstn, input logic [NREQ-1:0] req,
                           input logic [NREQ*DW-1:0] wd);
    int c;
    if (!rstn) begin
      mOwner = -1; mElapsed = 0; mPtr = 0; mDone = 0;
      mGnt = '0; mAck = 1'b0; mQ = '0; mBusy = 1'b0;
    end else if (mDone) begin
      mPtr   = (mOwner + 1) % int'(NREQ);
      mOwner = -1;
      mDone  = 0;
      mGnt   = '0;
      mAck   = 1'b0;
      mBusy  = 1'b0;
    end else if (mOwner < 0) begin
      mGnt = '0;
      for (int j = 0; j < int'(NREQ); j++) begin
        c = (mPtr + j) % int'(NREQ);
        if (mOwner < 0 && reqBit(req, c)) mOwner = c;
      end
      if (mOwner >= 0) begin
        mElapsed = 0;
        mGnt     = NREQ'(1) << mOwner;
        mBusy    = 1'b1;
      end
    end else if (!reqBit(req, mOwner)) begin
      mOwner = -1;
      mGnt   = '0;
      mBusy  = 1'b0;
    end else if (mElapsed == int'(HOLD) - 1) begin
      mQ    = DW'(wd >> (mOwner * int'(DW)));
      mAck  = 1'b1;
      mDone = 1;
    end else begin
      mElapsed++;
    end
  endtask

  // Drive one cycle of inputs, advance the model with them, compare outputs.
  task automatic step(input logic rstn, input logic [NREQ-1:0] req,
                      input logic [NREQ*DW-1:0] wd);
    RST_N = rstn;
    REQ   = req;
    WDATA = wd;
    @(posedge CLK);
    modelEdge(rstn, req, wd);
    #1;
    checkVal("gnt",    32'(GNT),  32'(mGnt));
    checkVal("ack",    32'(ACK),  32'(mAck));
    checkVal("q",      32'(Q),    32'(mQ));
    checkVal("busy",   32'(BUSY), 32'(mBusy));
    checkVal("onehot", 32'($countones(GNT) <= 1), 32'(1));
  endtask

  initial begin
    logic [NREQ-1:0]    rReq;
    logic [NREQ*DW-1:0] rWd;
    logic               rRst;

    CLK = 1'b0; RST_N = 1'b0; REQ = '0; WDATA = '0;
    assertCnt = 0; failCnt = 0;
    mOwner = -1; mElapsed = 0; mPtr = 0; mDone = 0;
    mGnt = '0; mAck = 1'b0; mQ = '0; mBusy = 1'b0;

    // Reset state
    step(1'b0, 4'b0000, 16'h0000);
    checkVal("rst_gnt",  32'(GNT),  32'h0);
    checkVal("rst_ack",  32'(ACK),  32'h0);
    checkVal("rst_q",    32'(Q),    32'h0);
    checkVal("rst_busy", 32'(BUSY), 32'h0);

    // Single request from requester 2
    step(1'b1, 4'b0100, 16'h0A00);
    checkVal("single_gnt",  32'(GNT),  32'h4);
    checkVal("single_busy", 32'(BUSY), 32'h1);
    step(1'b1, 4'b0100, 16'h0A00);
    step(1'b1, 4'b0100, 16'h0A00);
    checkVal("single_q",   32'(Q),   32'hA);
    checkVal("single_ack", 32'(ACK), 32'h1);
    step(1'b1, 4'b0000, 16'h0A00);
    checkVal("single_done_gnt", 32'(GNT), 32'h0);
    checkVal("single_done_ack", 32'(ACK), 32'h0);

    // Wrap: PTR=3, requesters 3 and 0 -> 3 first, then 0
    step(1'b1, 4'b1001, 16'h5006);
    checkVal("wrap_gnt3", 32'(GNT), 32'h8);
    step(1'b1, 4'b1001, 16'h5006);
    step(1'b1, 4'b1001, 16'h5006);
    checkVal("wrap_q3", 32'(Q), 32'h5);
    step(1'b1, 4'b1001, 16'h5006);
    step(1'b1, 4'b1001, 16'h5006);
    checkVal("wrap_gnt0", 32'(GNT), 32'h1);
    step(1'b1, 4'b1001, 16'h5006);
    step(1'b1, 4'b1001, 16'h5006);
    checkVal("wrap_q0", 32'(Q), 32'h6);
    step(1'b1, 4'b0000, 16'h5006);

    // Abort: requester 1 drops after one grant cycle; PTR stays at 1
    step(1'b1, 4'b0010, 16'h0000);
    checkVal("abort_gnt_on", 32'(GNT), 32'h2);
    step(1'b1, 4'b0000, 16'h0000);
    checkVal("abort_gnt",  32'(GNT),  32'h0);
    checkVal("abort_ack",  32'(ACK),  32'h0);
    checkVal("abort_q",    32'(Q),    32'h6);
    checkVal("abort_busy", 32'(BUSY), 32'h0);
    step(1'b1, 4'b1111, 16'h0000);
    checkVal("abort_ptr_kept", 32'(GNT), 32'h2);
    step(1'b1, 4'b0000, 16'h0000);

    // Late arrival: requester 1 rises during requester 0's grant
    step(1'b1, 4'b0001, 16'h00B7);
    checkVal("late_gnt0", 32'(GNT), 32'h1);
    step(1'b1, 4'b0011, 16'h00B7);
    checkVal("late_still0", 32'(GNT), 32'h1);
    step(1'b1, 4'b0011, 16'h00B7);
    checkVal("late_q", 32'(Q), 32'h7);
    step(1'b1, 4'b0010, 16'h00B7);
    checkVal("late_idle", 32'(GNT), 32'h0);
    step(1'b1, 4'b0010, 16'h00B7);
    checkVal("late_gnt1", 32'(GNT), 32'h2);

    // Reset mid-GRANT, then the next request starts from PTR=0
    step(1'b0, 4'b0010, 16'h00B7);
    checkVal("midrst_gnt",  32'(GNT),  32'h0);
    checkVal("midrst_ack",  32'(ACK),  32'h0);
    checkVal("midrst_q",    32'(Q),    32'h0);
    checkVal("midrst_busy", 32'(BUSY), 32'h0);
    step(1'b1, 4'b1111, 16'h4321);
    checkVal("midrst_ptr0", 32'(GNT), 32'h1);
    step(1'b1, 4'b0000, 16'h4321);

    // Fairness: all requesting, slices 1..4, grants every 4 cycles
    for (int k = 1; k <= 17; k++) begin
      step(1'b1, 4'b1111, 16'h4321);
      if (k % 4 == 1)
        checkVal("fair_gnt", 32'(GNT), 32'(1) << (((k - 1) / 4) % 4));
      if (k % 4 == 3) begin
        checkVal("fair_q",   32'(Q),   32'((k - 3) / 4 + 1));
        checkVal("fair_ack", 32'(ACK), 32'h1);
      end
    end
    step(1'b1, 4'b0000, 16'h4321);

    // Random traffic with sticky requests and occasional resets
    rReq = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) rReq = NREQ'($urandom_range(0, 15));
      rWd  = (NREQ*DW)'($urandom);
      rRst = ($urandom_range(0, 99) != 0);
      step(rRst, rReq, rWd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
